// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ttt_pkg
//  Description : Shared state encoding, cell codes and winner codes for the
//                tic-tac-toe game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ttt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PLAY  = 4'd1,
        ST_CHECK = 4'd2,
        ST_WIN   = 4'd3,
        ST_DRAW  = 4'd4
    } state_t;

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_X    = 2'b01;
    localparam logic [1:0] WINNER_O    = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    // A disabled timer (0 cycles) still needs a 1-bit register.
    function automatic int timer_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ttt_game_ctrl_if
//  Description : Button pulses in, board/game state out, between the game
//                controller and the VGA top level.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ttt_game_ctrl_if #(
    parameter int N = 3
);
    localparam int CURSOR_W = $clog2(N * N);

    logic                  start;
    logic                  abort;
    logic                  sel;
    logic                  confirm;
    logic [2*N*N-1:0]      board;
    logic [CURSOR_W-1:0]   cursor;
    logic                  turn;
    logic [3:0]            estado;
    logic [1:0]            winner;
    logic                  load;
    logic                  err;
    logic                  timeout;

    modport master (
        output start, abort, sel, confirm,
        input  board, cursor, turn, estado, winner, load, err, timeout
    );

    modport slave (
        input  start, abort, sel, confirm,
        output board, cursor, turn, estado, winner, load, err, timeout
    );

endinterface
`default_nettype wire

// File: rtl/ttt_line_checker.sv
`default_nettype none
// ============================================================================
//  Module      : ttt_line_checker
//  Description : Combinational detection of a complete row, column or
//                diagonal for either mark, plus a board-full flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ttt_line_checker
    import ttt_pkg::*;
#(
    parameter int N = 3
) (
    input  wire logic [2*N*N-1:0] board,
    output logic                  x_win,
    output logic                  o_win,
    output logic                  full
);

    logic w_row_x, w_row_o, w_col_x, w_col_o;
    logic w_diag_x, w_diag_o, w_anti_x, w_anti_o;

    always_comb begin
        x_win    = 1'b0;
        o_win    = 1'b0;
        full     = 1'b1;
        w_row_x  = 1'b1;
        w_row_o  = 1'b1;
        w_col_x  = 1'b1;
        w_col_o  = 1'b1;
        w_diag_x = 1'b1;
        w_diag_o = 1'b1;
        w_anti_x = 1'b1;
        w_anti_o = 1'b1;
        for (int i = 0; i < N; i++) begin
            w_row_x = 1'b1;
            w_row_o = 1'b1;
            w_col_x = 1'b1;
            w_col_o = 1'b1;
            for (int j = 0; j < N; j++) begin
                w_row_x &= (board[2*(i*N+j) +: 2] == MARK_X);
                w_row_o &= (board[2*(i*N+j) +: 2] == MARK_O);
                w_col_x &= (board[2*(j*N+i) +: 2] == MARK_X);
                w_col_o &= (board[2*(j*N+i) +: 2] == MARK_O);
            end
            x_win |= w_row_x | w_col_x;
            o_win |= w_row_o | w_col_o;
            w_diag_x &= (board[2*(i*N+i) +: 2] == MARK_X);
            w_diag_o &= (board[2*(i*N+i) +: 2] == MARK_O);
            w_anti_x &= (board[2*(i*N+N-1-i) +: 2] == MARK_X);
            w_anti_o &= (board[2*(i*N+N-1-i) +: 2] == MARK_O);
        end
        x_win |= w_diag_x | w_anti_x;
        o_win |= w_diag_o | w_anti_o;
        for (int k = 0; k < N*N; k++) begin
            full &= (board[2*k +: 2] != EMPTY);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ttt_game_ctrl
//  Description : N x N tic-tac-toe controller: board, cursor, turn order,
//                per-turn timeout and win/draw detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int N           = 3,
    parameter int TURN_CYCLES = 250_000_000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ttt_game_ctrl_if.slave   bus
);

    localparam int c_CELLS    = N * N;
    localparam int c_CURSOR_W = $clog2(c_CELLS);
    localparam int c_TIMER_W  = timer_width(TURN_CYCLES);

    localparam logic [c_TIMER_W-1:0]  c_TIMER_LOAD =
        (TURN_CYCLES > 0) ? c_TIMER_W'(TURN_CYCLES - 1) : '0;
    localparam logic                  c_TIMER_EN   = (TURN_CYCLES > 0);
    localparam logic [c_CURSOR_W-1:0] c_LAST_CELL  = c_CURSOR_W'(c_CELLS - 1);

    state_t                  r_state;
    logic [2*c_CELLS-1:0]    r_board;
    logic [c_CURSOR_W-1:0]   r_cursor;
    logic                    r_turn;
    logic [1:0]              r_winner;
    logic                    r_load;
    logic                    r_err;
    logic                    r_timeout;
    logic [c_TIMER_W-1:0]    r_timer;

    logic                    w_x_win;
    logic                    w_o_win;
    logic                    w_full;
    logic [1:0]              w_cell;
    logic [1:0]              w_mark;
    logic [c_CURSOR_W-1:0]   w_cursor_next;
    logic                    w_timer_zero;

    // Evaluated on the registered board, so the verdict is ready in CHECK.
    ttt_line_checker #(
        .N (N)
    ) u_line_checker (
        .board (r_board),
        .x_win (w_x_win),
        .o_win (w_o_win),
        .full  (w_full)
    );

    assign w_cell        = r_board[2*r_cursor +: 2];
    assign w_mark        = r_turn ? MARK_O : MARK_X;
    assign w_cursor_next = (r_cursor == c_LAST_CELL) ? '0 : r_cursor + c_CURSOR_W'(1);
    assign w_timer_zero  = (r_timer == '0);

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            r_state   <= ST_IDLE;
            r_board   <= '0;
            r_cursor  <= '0;
            r_turn    <= 1'b0;
            r_winner  <= WINNER_NONE;
            r_load    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_timer   <= c_TIMER_LOAD;
        end else begin
            r_load    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WIN, ST_DRAW: begin
                    if (bus.start) begin
                        r_state  <= ST_PLAY;
                        r_board  <= '0;
                        r_cursor <= '0;
                        r_turn   <= 1'b0;
                        r_winner <= WINNER_NONE;
                        r_timer  <= c_TIMER_LOAD;
                    end
                end
                ST_PLAY: begin
                    // confirm wins over sel; a blocked expiry fires on the next free cycle
                    if (bus.confirm) begin
                        if (w_cell == EMPTY) begin
                            r_board[2*r_cursor +: 2] <= w_mark;
                            r_load                   <= 1'b1;
                            r_state                  <= ST_CHECK;
                        end else begin
                            r_err <= 1'b1;
                            if (!w_timer_zero) r_timer <= r_timer - c_TIMER_W'(1);
                        end
                    end else if (bus.sel) begin
                        r_cursor <= w_cursor_next;
                        if (!w_timer_zero) r_timer <= r_timer - c_TIMER_W'(1);
                    end else if (c_TIMER_EN && w_timer_zero) begin
                        r_timeout <= 1'b1;
                        r_turn    <= ~r_turn;
                        r_timer   <= c_TIMER_LOAD;
                    end else if (!w_timer_zero) begin
                        r_timer <= r_timer - c_TIMER_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (w_x_win) begin
                        r_winner <= WINNER_X;
                        r_state  <= ST_WIN;
                    end else if (w_o_win) begin
                        r_winner <= WINNER_O;
                        r_state  <= ST_WIN;
                    end else if (w_full) begin
                        r_winner <= WINNER_DRAW;
                        r_state  <= ST_DRAW;
                    end else begin
                        r_turn  <= ~r_turn;
                        r_timer <= c_TIMER_LOAD;
                        r_state <= ST_PLAY;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.board   = r_board;
    assign bus.cursor  = r_cursor;
    assign bus.turn    = r_turn;
    assign bus.estado  = r_state;
    assign bus.winner  = r_winner;
    assign bus.load    = r_load;
    assign bus.err     = r_err;
    assign bus.timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ttt_game_ctrl
//  Description : Directed scoreboard bench for ttt_game_ctrl (two 3x3 boards
//                with different turn limits and one 4x4 board).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_game_ctrl;

    localparam int F_BOARD = 0, F_CURSOR = 1, F_TURN = 2, F_ESTADO = 3;
    localparam int F_WINNER = 4, F_LOAD = 5, F_ERR = 6, F_TIMEOUT = 7;
    localparam int W_A = 0, W_T = 1, W_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, sel = 1'b0, confirm = 1'b0;

    always #5 clk = ~clk;

    ttt_game_ctrl_if #(.N(3)) if_a ();
    ttt_game_ctrl_if #(.N(3)) if_t ();
    ttt_game_ctrl_if #(.N(4)) if_b ();

    assign if_a.start = start;  assign if_a.abort = abort;
    assign if_a.sel   = sel;    assign if_a.confirm = confirm;
    assign if_t.start = start;  assign if_t.abort = abort;
    assign if_t.sel   = sel;    assign if_t.confirm = confirm;
    assign if_b.start = start;  assign if_b.abort = abort;
    assign if_b.sel   = sel;    assign if_b.confirm = confirm;

    ttt_game_ctrl #(.N(3), .TURN_CYCLES(1000)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    ttt_game_ctrl #(.N(3), .TURN_CYCLES(10))   dut_t (.clk(clk), .rst(rst), .bus(if_t));
    ttt_game_ctrl #(.N(4), .TURN_CYCLES(0))    dut_b (.clk(clk), .rst(rst), .bus(if_b));

    typedef struct {
        string       tag;
        int          which;
        int          field;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] m_board  [3];
    int          m_cursor [3];
    logic        m_turn   [3];
    int          m_cells  [3] = '{9, 9, 16};

    function automatic logic [31:0] observe(input int which, input int field);
        logic [31:0] v;
        v = '0;
        case (which)
            W_A: case (field)
                F_BOARD:  v = 32'(if_a.board);   F_CURSOR:  v = 32'(if_a.cursor);
                F_TURN:   v = 32'(if_a.turn);    F_ESTADO:  v = 32'(if_a.estado);
                F_WINNER: v = 32'(if_a.winner);  F_LOAD:    v = 32'(if_a.load);
                F_ERR:    v = 32'(if_a.err);     default:   v = 32'(if_a.timeout);
            endcase
            W_T: case (field)
                F_BOARD:  v = 32'(if_t.board);   F_CURSOR:  v = 32'(if_t.cursor);
                F_TURN:   v = 32'(if_t.turn);    F_ESTADO:  v = 32'(if_t.estado);
                F_WINNER: v = 32'(if_t.winner);  F_LOAD:    v = 32'(if_t.load);
                F_ERR:    v = 32'(if_t.err);     default:   v = 32'(if_t.timeout);
            endcase
            default: case (field)
                F_BOARD:  v = 32'(if_b.board);   F_CURSOR:  v = 32'(if_b.cursor);
                F_TURN:   v = 32'(if_b.turn);    F_ESTADO:  v = 32'(if_b.estado);
                F_WINNER: v = 32'(if_b.winner);  F_LOAD:    v = 32'(if_b.load);
                F_ERR:    v = 32'(if_b.err);     default:   v = 32'(if_b.timeout);
            endcase
        endcase
        return v;
    endfunction

    task automatic expect_out(input string tag, input int which, input int field,
                              input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.which = which; e.field = field; e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Advance one clock and check everything queued for this cycle.
    task automatic step();
        sb_t         e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.which, e.field);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic new_game(input int w);
        m_board[w]  = '0;
        m_cursor[w] = 0;
        m_turn[w]   = 1'b0;
    endtask

    task automatic move_cursor(input int w, input int target, input string tag);
        while (m_cursor[w] != target) begin
            sel = 1'b1;
            m_cursor[w] = (m_cursor[w] + 1) % m_cells[w];
            expect_out({tag, "_cursor"}, w, F_CURSOR, 32'(m_cursor[w]));
            step();
            sel = 1'b0;
        end
    endtask

    task automatic place(input int w, input string tag, input int next_state);
        confirm = 1'b1;
        m_board[w][2*m_cursor[w] +: 2] = m_turn[w] ? 2'b10 : 2'b01;
        expect_out({tag, "_load"},  w, F_LOAD,   32'd1);
        expect_out({tag, "_check"}, w, F_ESTADO, 32'd2);
        expect_out({tag, "_board"}, w, F_BOARD,  m_board[w]);
        step();
        confirm = 1'b0;
        expect_out({tag, "_state"}, w, F_ESTADO, 32'(next_state));
        expect_out({tag, "_load0"}, w, F_LOAD,   32'd0);
        if (next_state == 1) begin
            m_turn[w] = ~m_turn[w];
            expect_out({tag, "_turn"}, w, F_TURN, 32'(m_turn[w]));
        end
        step();
    endtask

    initial begin
        for (int w = 0; w < 3; w++) new_game(w);

        step();
        expect_out("rst_board",   W_A, F_BOARD,   32'd0);
        expect_out("rst_cursor",  W_A, F_CURSOR,  32'd0);
        expect_out("rst_turn",    W_A, F_TURN,    32'd0);
        expect_out("rst_estado",  W_A, F_ESTADO,  32'd0);
        expect_out("rst_winner",  W_A, F_WINNER,  32'd0);
        expect_out("rst_load",    W_A, F_LOAD,    32'd0);
        expect_out("rst_err",     W_A, F_ERR,     32'd0);
        expect_out("rst_timeout", W_A, F_TIMEOUT, 32'd0);
        expect_out("rst_board4",  W_B, F_BOARD,   32'd0);
        step();
        rst = 1'b0;

        // Game 1: X wins on the top row.
        start = 1'b1;
        expect_out("g1_start", W_A, F_ESTADO, 32'd1);
        step();
        start = 1'b0;
        new_game(W_A);
        move_cursor(W_A, 0, "g1_x0"); place(W_A, "g1_x0", 1);
        move_cursor(W_A, 3, "g1_o3"); place(W_A, "g1_o3", 1);
        move_cursor(W_A, 1, "g1_x1"); place(W_A, "g1_x1", 1);
        move_cursor(W_A, 4, "g1_o4"); place(W_A, "g1_o4", 1);
        move_cursor(W_A, 2, "g1_x2"); place(W_A, "g1_x2", 3);
        sel = 1'b1;
        expect_out("g1_winner",     W_A, F_WINNER, 32'd1);
        expect_out("g1_board_lit",  W_A, F_BOARD,  32'h295);
        expect_out("g1_cursor_hold", W_A, F_CURSOR, 32'd2);
        step();
        sel = 1'b0;
        confirm = 1'b1;
        expect_out("g1_win_board", W_A, F_BOARD,  32'h295);
        expect_out("g1_win_load",  W_A, F_LOAD,   32'd0);
        expect_out("g1_win_state", W_A, F_ESTADO, 32'd3);
        step();
        confirm = 1'b0;

        // Game 2: cursor wrap, occupied confirm, confirm+sel, abort in CHECK.
        start = 1'b1;
        expect_out("g2_start",  W_A, F_ESTADO, 32'd1);
        expect_out("g2_board",  W_A, F_BOARD,  32'd0);
        expect_out("g2_cursor", W_A, F_CURSOR, 32'd0);
        expect_out("g2_winner", W_A, F_WINNER, 32'd0);
        step();
        start = 1'b0;
        new_game(W_A);
        for (int i = 0; i < 9; i++) begin
            sel = 1'b1;
            m_cursor[W_A] = (m_cursor[W_A] + 1) % 9;
            expect_out("g2_wrap", W_A, F_CURSOR, 32'(m_cursor[W_A]));
            step();
        end
        sel = 1'b0;
        expect_out("g2_wrap_zero", W_A, F_CURSOR, 32'd0);
        step();
        move_cursor(W_A, 4, "g2_x4"); place(W_A, "g2_x4", 1);
        confirm = 1'b1;
        expect_out("occ_err",   W_A, F_ERR,    32'd1);
        expect_out("occ_board", W_A, F_BOARD,  m_board[W_A]);
        expect_out("occ_turn",  W_A, F_TURN,   32'd1);
        expect_out("occ_load",  W_A, F_LOAD,   32'd0);
        expect_out("occ_state", W_A, F_ESTADO, 32'd1);
        step();
        confirm = 1'b0;
        expect_out("occ_err0", W_A, F_ERR, 32'd0);
        step();
        move_cursor(W_A, 5, "cs_o5");
        sel = 1'b1;
        confirm = 1'b1;
        m_board[W_A][11:10] = 2'b10;
        expect_out("cs_load",   W_A, F_LOAD,   32'd1);
        expect_out("cs_cursor", W_A, F_CURSOR, 32'd5);
        expect_out("cs_board",  W_A, F_BOARD,  m_board[W_A]);
        step();
        sel = 1'b0;
        confirm = 1'b0;
        expect_out("cs_turn", W_A, F_TURN, 32'd0);
        step();
        move_cursor(W_A, 6, "ab_x6");
        confirm = 1'b1;
        expect_out("ab_check", W_A, F_ESTADO, 32'd2);
        step();
        confirm = 1'b0;
        abort = 1'b1;
        expect_out("ab_state",  W_A, F_ESTADO, 32'd0);
        expect_out("ab_board",  W_A, F_BOARD,  32'd0);
        expect_out("ab_cursor", W_A, F_CURSOR, 32'd0);
        expect_out("ab_turn",   W_A, F_TURN,   32'd0);
        step();
        abort = 1'b0;

        // Game 3: full board, no line.
        start = 1'b1;
        step();
        start = 1'b0;
        new_game(W_A);
        move_cursor(W_A, 0, "d_x0"); place(W_A, "d_x0", 1);
        move_cursor(W_A, 1, "d_o1"); place(W_A, "d_o1", 1);
        move_cursor(W_A, 2, "d_x2"); place(W_A, "d_x2", 1);
        move_cursor(W_A, 4, "d_o4"); place(W_A, "d_o4", 1);
        move_cursor(W_A, 3, "d_x3"); place(W_A, "d_x3", 1);
        move_cursor(W_A, 5, "d_o5"); place(W_A, "d_o5", 1);
        move_cursor(W_A, 7, "d_x7"); place(W_A, "d_x7", 1);
        move_cursor(W_A, 6, "d_o6"); place(W_A, "d_o6", 1);
        move_cursor(W_A, 8, "d_x8"); place(W_A, "d_x8", 4);
        expect_out("d_winner", W_A, F_WINNER, 32'd3);
        expect_out("d_estado", W_A, F_ESTADO, 32'd4);
        step();

        // Turn timeout on the 10-cycle controller.
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b1;
        expect_out("to_start", W_T, F_ESTADO, 32'd1);
        step();
        start = 1'b0;
        new_game(W_A);
        for (int i = 0; i < 9; i++) begin
            expect_out("to_early", W_T, F_TIMEOUT, 32'd0);
            step();
        end
        expect_out("to_pulse", W_T, F_TIMEOUT, 32'd1);
        expect_out("to_turn1", W_T, F_TURN,    32'd1);
        expect_out("to_board", W_T, F_BOARD,   32'd0);
        expect_out("to_state", W_T, F_ESTADO,  32'd1);
        step();
        expect_out("to_pulse0", W_T, F_TIMEOUT, 32'd0);
        step();
        repeat (8) step();
        expect_out("to_pulse2", W_T, F_TIMEOUT, 32'd1);
        expect_out("to_turn0",  W_T, F_TURN,    32'd0);
        step();

        // rst in the middle of a game.
        move_cursor(W_A, 2, "r_x2"); place(W_A, "r_x2", 1);
        rst = 1'b1;
        expect_out("rst_mid_state",  W_A, F_ESTADO, 32'd0);
        expect_out("rst_mid_board",  W_A, F_BOARD,  32'd0);
        expect_out("rst_mid_cursor", W_A, F_CURSOR, 32'd0);
        expect_out("rst_mid_turn",   W_A, F_TURN,   32'd0);
        step();
        rst = 1'b0;

        // 4x4: O completes the anti-diagonal 3,6,9,12.
        start = 1'b1;
        expect_out("b_start", W_B, F_ESTADO, 32'd1);
        step();
        start = 1'b0;
        new_game(W_B);
        move_cursor(W_B, 0,  "b_x0");  place(W_B, "b_x0",  1);
        move_cursor(W_B, 3,  "b_o3");  place(W_B, "b_o3",  1);
        move_cursor(W_B, 1,  "b_x1");  place(W_B, "b_x1",  1);
        move_cursor(W_B, 6,  "b_o6");  place(W_B, "b_o6",  1);
        move_cursor(W_B, 2,  "b_x2");  place(W_B, "b_x2",  1);
        move_cursor(W_B, 9,  "b_o9");  place(W_B, "b_o9",  1);
        move_cursor(W_B, 4,  "b_x4");  place(W_B, "b_x4",  1);
        move_cursor(W_B, 12, "b_o12"); place(W_B, "b_o12", 3);
        expect_out("b_winner", W_B, F_WINNER, 32'd2);
        expect_out("b_estado", W_B, F_ESTADO, 32'd3);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Parametrised N×N tic-tac-toe game controller that replaces the fixed 3×3 board register and two-state screen select in the VGA game top level. It owns the board, the cursor, turn alternation, per-turn timeout, and win/draw detection, and it exposes the board and game state to the video generator and the screen multiplexer. Inputs are single-cycle pulses from the existing button debouncers.

## Interface
- N, default 3: board side; legal values 3..8; a win is N in a row.
- TURN_CYCLES, default 250_000_000: clk cycles allowed per turn before timeout; 0 disables the timeout.
- clk  in  1  system clock (50 MHz board clock).
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins a new game from IDLE, WIN or DRAW.
- abort  in  1  pulse; returns to IDLE from any state.
- sel  in  1  pulse; advances the cursor by one cell.
- confirm  in  1  pulse; places the current player's mark at the cursor.
- board  out  2·N·N  cell i occupies bits [2i+1:2i]; 00 empty, 01 X, 10 O; cell 0 is the top-left cell; row-major order.
- cursor  out  $clog2(N·N)  selected cell index.
- turn  out  1  0 = X to move, 1 = O to move.
- estado  out  4  encoded game state, for the screen mux and LEDs.
- winner  out  2  00 none, 01 X, 10 O, 11 draw.
- load  out  1  one-cycle pulse in the cycle the board register is written.
- err  out  1  one-cycle pulse when confirm hits an occupied cell.
- timeout  out  1  one-cycle pulse when a turn expires.

## Operation
- States: IDLE=0, PLAY=1, CHECK=2, WIN=3, DRAW=4.
- Reset and IDLE: board all 00, cursor 0, turn 0, winner 00, pulses 0, estado 0.
- IDLE + start: enter PLAY; board cleared, cursor 0, turn 0, timer loaded.
- PLAY + sel: cursor +1; wraps N·N−1 → 0.
- PLAY + confirm, empty cell: write the cell (01 if turn=0, otherwise 10), pulse load, go to CHECK.
- PLAY + confirm, occupied cell: board unchanged, pulse err, stay in PLAY, timer keeps running.
- PLAY, timer reaches 0 (TURN_CYCLES≠0): pulse timeout, toggle turn, reload timer, stay in PLAY, no mark placed.
- CHECK: evaluate all N rows, N columns and both diagonals on the registered board.
  - Line complete → WIN, winner = that mark.
  - Else all cells non-empty → DRAW, winner = 11.
  - Else toggle turn, reload timer, go to PLAY.
  - Win has priority over draw.
- WIN/DRAW: board, winner and cursor hold; start behaves as in IDLE (new game); sel and confirm are ignored.
- Priority within one cycle: rst > abort > start > confirm > sel > timer expiry. When confirm and sel arrive together, the mark uses the pre-increment cursor and sel is dropped.
- abort in any state: next cycle is IDLE with reset values.
- Cursor is kept across turns and reset only at game start.

## Timing
- confirm in cycle t: board and load in cycle t+1 (state CHECK); state PLAY, WIN or DRAW in cycle t+2.
- sel in cycle t: cursor updates in cycle t+1.
- Timer: loaded with TURN_CYCLES−1 on PLAY entry and decremented each PLAY cycle; expiry pulse in the cycle after it reads 0.
- All outputs are registered; there are no combinational input-to-output paths.
- rst asserted mid-game: IDLE state and reset values on the next edge.

## Structure
- Package ttt_pkg: state_t enum (4-bit), cell constants EMPTY/MARK_X/MARK_O, winner codes.
- Sub-module ttt_line_checker (combinational, parameter N): board in; x_win, o_win, full out.
- Timer width is $clog2(TURN_CYCLES+1), minimum 1.

## Test plan
- N=3: X plays cells 0, O plays 3, X plays 1, O plays 4, X plays 2 → WIN in cycle t+2 after the last confirm; winner=01; board=…_00_00_00_00_00_10_10_01_01_01 (cell 0 in the LSBs).
- N=3, full board with no line (X:0,2,3,7,8 / O:1,4,5,6) → winner=11, estado=4.
- Confirm on occupied cell 4 → err=1 for one cycle, board unchanged, turn unchanged.
- TURN_CYCLES=10, no input for 10 PLAY cycles → timeout pulse, turn 0→1, board unchanged.
- 9 sel pulses at N=3 → cursor back to 0. N=4, anti-diagonal O win (3,6,9,12) → winner=10.
- abort during CHECK, and rst mid-PLAY → next cycle IDLE, board 0, cursor 0; confirm+sel in the same cycle → mark at the old cursor, cursor unchanged.
